// File: rtl/huff_pkg.sv
// Shared types and widths for the Huffman stream controller and its symbol FIFO.
package huff_pkg;
  localparam int SYM_W  = 6;
  localparam int BYTE_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, ERR} ctrl_state_t;
endpackage

// File: rtl/huff_sym_fifo.sv
// Small symbol FIFO; supports push and pop in the same cycle, including push while full with a pop.
module huff_sym_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == FULL_CNT);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    rd_data = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries data only; occupancy is governed by the reset pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/huffman_stream_ctrl.sv
// Feeds packed code bytes MSB-first into the serial Huffman decoder and
// buffers the decoded symbols, tracking per-frame symbol count and code errors.
module huffman_stream_ctrl
  import huff_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  frame_len,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dec_bit,
  output logic              dec_bit_vld,
  output logic              dec_clr,
  input  logic [SYM_W-1:0]  dec_sym,
  input  logic              dec_sym_vld,
  input  logic              dec_err,
  output logic [SYM_W-1:0]  sym_out,
  output logic              sym_vld,
  input  logic              sym_rdy,
  output logic              busy,
  output logic              done,
  output logic              err
);
  ctrl_state_t       state_q, state_d;
  logic [BYTE_W-1:0] sreg_q, sreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, tgt_q, tgt_d, cnt_inc;
  logic              err_q, err_d, dec_clr_q, dec_clr_d;
  logic              fifo_full, fifo_empty, push;

  huff_sym_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(SYM_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (sym_rdy),
    .wr_data (dec_sym),
    .rd_data (sym_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    err_d       = err_q;
    dec_clr_d   = 1'b0;
    in_ready    = (state_q == LOAD);
    dec_bit     = sreg_q[idx_q];
    // Stalling on a full FIFO guarantees every emitted symbol has a slot.
    dec_bit_vld = (state_q == SHIFT) && !fifo_full;
    push        = dec_bit_vld && dec_sym_vld;
    cnt_inc     = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d     = frame_len;
          cnt_d     = '0;
          err_d     = 1'b0;
          dec_clr_d = 1'b1;
          state_d   = (frame_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          sreg_d  = in_data;
          idx_d   = IDX_W'(BYTE_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (dec_bit_vld) begin
          if (dec_err) begin
            err_d     = 1'b1;
            dec_clr_d = 1'b1;
            state_d   = ERR;
          end else if (dec_sym_vld && (cnt_inc == tgt_q)) begin
            cnt_d     = cnt_inc;
            dec_clr_d = 1'b1;
            state_d   = DONE;
          end else begin
            // Decoder prefix is kept across bytes, so no clear on reload.
            if (dec_sym_vld) cnt_d = cnt_inc;
            if (idx_q == '0) state_d = LOAD;
            else             idx_d   = idx_q - 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    err     = err_q;
    dec_clr = dec_clr_q;
    sym_vld = !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      tgt_q     <= '0;
      err_q     <= 1'b0;
      dec_clr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      err_q     <= err_d;
      dec_clr_q <= dec_clr_d;
    end
  end

  always_ff @(posedge clk) begin
    sreg_q <= sreg_d;
  end
endmodule

// File: tb/tb_huffman_stream_ctrl.sv
// Bench for huffman_stream_ctrl: behavioural decoder core, symbol encoder for
// stimulus, and scenario tasks comparing popped symbols against the encoded list.
`timescale 1ns/1ps
module tb_huffman_stream_ctrl;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, in_ready;
  logic [CNT_W-1:0] frame_len;
  logic [7:0]       in_data;
  logic             dec_bit, dec_bit_vld, dec_clr, dec_sym_vld, dec_err;
  logic [5:0]       dec_sym, sym_out;
  logic             sym_vld, sym_rdy, busy, done, err;

  int n_pass = 0;
  int n_chk  = 0;

  int         exp_q[$];
  int         got_q[$];
  logic [7:0] feed_q[$];
  bit         bits_q[$];

  always #5 clk = ~clk;

  huffman_stream_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dec_bit(dec_bit), .dec_bit_vld(dec_bit_vld), .dec_clr(dec_clr),
    .dec_sym(dec_sym), .dec_sym_vld(dec_sym_vld), .dec_err(dec_err),
    .sym_out(sym_out), .sym_vld(sym_vld), .sym_rdy(sym_rdy),
    .busy(busy), .done(done), .err(err)
  );

  // Code table: 00->1 01->2 10->3 110->4 1110ab->5+ab ; 8 bits unmatched -> error
  function automatic int lookup(input logic [7:0] b, input int n);
    if (n == 2 && b[1:0] != 2'b11) return int'(b[1:0]) + 1;
    if (n == 3 && b[2:0] == 3'b110) return 4;
    if (n == 6 && b[5:2] == 4'b1110) return 5 + int'(b[1:0]);
    return 0;
  endfunction

  logic [7:0] pfx_q, cur;
  int         pfx_len_q, cur_len, cur_sym;

  always_comb begin
    cur         = {pfx_q[6:0], dec_bit};
    cur_len     = pfx_len_q + 1;
    cur_sym     = lookup(cur, cur_len);
    dec_sym_vld = dec_bit_vld && (cur_sym != 0);
    dec_sym     = 6'(cur_sym);
    dec_err     = dec_bit_vld && (cur_sym == 0) && (cur_len >= 8);
  end

  always @(posedge clk) begin
    if (rst || dec_clr) begin
      pfx_q     <= '0;
      pfx_len_q <= 0;
    end else if (dec_bit_vld) begin
      if (cur_sym != 0 || cur_len >= 8) begin
        pfx_q     <= '0;
        pfx_len_q <= 0;
      end else begin
        pfx_q     <= cur;
        pfx_len_q <= cur_len;
      end
    end
  end

  task automatic encode(input int s);
    case (s)
      1: begin bits_q.push_back(0); bits_q.push_back(0); end
      2: begin bits_q.push_back(0); bits_q.push_back(1); end
      3: begin bits_q.push_back(1); bits_q.push_back(0); end
      4: begin bits_q.push_back(1); bits_q.push_back(1); bits_q.push_back(0); end
      default: begin
        bits_q.push_back(1); bits_q.push_back(1); bits_q.push_back(1); bits_q.push_back(0);
        bits_q.push_back(bit'(((s - 5) >> 1) & 1)); bits_q.push_back(bit'((s - 5) & 1));
      end
    endcase
  endtask

  task automatic build_random(input int nsym);
    logic [7:0] b;
    int s;
    exp_q.delete(); feed_q.delete(); bits_q.delete();
    for (int i = 0; i < nsym; i++) begin
      s = int'($urandom_range(1, 8));
      exp_q.push_back(s);
      encode(s);
    end
    while (bits_q.size() != 0) begin
      b = 8'h00;
      for (int k = 0; k < 8; k++) b = {b[6:0], (bits_q.size() != 0) ? bits_q.pop_front() : 1'b0};
      feed_q.push_back(b);
    end
  endtask

  task automatic pulse_start(input int len);
    @(negedge clk);
    start = 1'b1; frame_len = CNT_W'(len); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 held low until FIFO fills then released
  task automatic run_frame(input int len, input int rdy_mode, input int restart_at, input string nm);
    int cyc = 0, done_cnt = 0, pushes = 0, stall = 0, acc_cyc = -1, bit_cyc = -1, n;
    bit released = 1'b0, fin = 1'b0;
    got_q.delete();
    pulse_start(len);
    while (!fin && cyc < 3000) begin
      start = (cyc == restart_at);
      if (start) frame_len = CNT_W'(1);
      in_valid = (feed_q.size() != 0) && ($urandom_range(0, 3) != 0);
      in_data  = in_valid ? feed_q[0] : 8'($urandom);
      case (rdy_mode)
        0:       sym_rdy = 1'b1;
        1:       sym_rdy = 1'($urandom_range(0, 1));
        default: sym_rdy = released;
      endcase
      #1;
      if (rdy_mode == 2 && !released && pushes >= FIFO_DEPTH) begin
        n_chk++;
        if (dec_bit_vld !== 1'b0 || sym_vld !== 1'b1)
          $display("FAIL %s stall: dec_bit_vld=%b sym_vld=%b, required 0 and 1", nm, dec_bit_vld, sym_vld);
        else n_pass++;
        stall++;
        if (stall == 3) released = 1'b1;
      end
      if (in_valid && in_ready) begin
        void'(feed_q.pop_front());
        if (acc_cyc < 0) acc_cyc = cyc;
      end
      if (dec_bit_vld && bit_cyc < 0) bit_cyc = cyc;
      if (dec_bit_vld && dec_sym_vld) pushes++;
      if (sym_vld && sym_rdy) got_q.push_back(int'(sym_out));
      if (done) done_cnt++;
      if (done_cnt > 0 && !done && !sym_vld) fin = 1'b1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; sym_rdy = 1'b0;
    n_chk++;
    if (!fin) $display("FAIL %s timeout: finished=%0b, required 1", nm, fin); else n_pass++;
    n_chk++;
    if (done_cnt != 1) $display("FAIL %s done_width: %0d cycles, required 1", nm, done_cnt); else n_pass++;
    n_chk++;
    if (bit_cyc - acc_cyc != 1) $display("FAIL %s first_bit_latency: %0d, required 1", nm, bit_cyc - acc_cyc);
    else n_pass++;
    n_chk++;
    if (got_q.size() != exp_q.size())
      $display("FAIL %s sym_count: %0d, required %0d", nm, got_q.size(), exp_q.size());
    else n_pass++;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_chk++;
      if (got_q[i] != exp_q[i]) $display("FAIL %s sym[%0d]: %0d, required %0d", nm, i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_chk++;
    if (in_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s idle_after: in_ready=%b busy=%b, required 0 0", nm, in_ready, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; sym_rdy = 1'b0; frame_len = '0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({in_ready, dec_bit_vld, dec_clr, sym_vld, busy, done, err} !== 7'b0010000)
      $display("FAIL reset_state: %b, required 0010000",
               {in_ready, dec_bit_vld, dec_clr, sym_vld, busy, done, err});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (dec_clr !== 1'b0) $display("FAIL reset_clr_release: dec_clr=%b, required 0", dec_clr); else n_pass++;
  endtask

  task automatic test_directed();
    feed_q = '{8'h1B, 8'h00};
    exp_q  = '{1, 2, 3, 4};
    run_frame(4, 0, -1, "directed");
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 6; f++) begin
      build_random(int'($urandom_range(1, 20)));
      run_frame(exp_q.size(), 1, -1, "random");
    end
  endtask

  task automatic test_backpressure();
    build_random(10);
    run_frame(10, 2, -1, "backpressure");
  endtask

  task automatic test_zero_len();
    bit rdy_seen = 1'b0;
    pulse_start(0);
    n_chk++;
    if (done !== 1'b1 || dec_clr !== 1'b1)
      $display("FAIL zero_len_done: done=%b dec_clr=%b, required 1 1", done, dec_clr);
    else n_pass++;
    in_valid = 1'b1; in_data = 8'h00;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero_len_after: done=%b busy=%b, required 0 0", done, busy);
    else n_pass++;
    repeat (6) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_chk++;
    if (rdy_seen) $display("FAIL zero_len_ready: in_ready seen=%b, required 0", rdy_seen); else n_pass++;
  endtask

  task automatic test_error();
    int cyc = 0;
    feed_q = '{8'hFF, 8'hFF};
    pulse_start(3);
    sym_rdy = 1'b0;
    while (cyc < 100) begin
      in_valid = (feed_q.size() != 0);
      in_data  = in_valid ? feed_q[0] : 8'h00;
      #1;
      if (in_valid && in_ready) void'(feed_q.pop_front());
      if (dec_err) break;
      @(negedge clk);
      cyc++;
    end
    n_chk++;
    if (dec_err !== 1'b1) $display("FAIL err_seen: dec_err=%b, required 1", dec_err); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++;
    if ({err, dec_clr, busy} !== 3'b111)
      $display("FAIL err_state: err,dec_clr,busy=%b, required 111", {err, dec_clr, busy});
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({err, dec_clr, busy, in_ready, sym_vld} !== 5'b10000)
      $display("FAIL err_idle: err,dec_clr,busy,in_ready,sym_vld=%b, required 10000",
               {err, dec_clr, busy, in_ready, sym_vld});
    else n_pass++;
    feed_q = '{8'h00};
    exp_q  = '{1, 1};
    run_frame(2, 0, -1, "after_err");
    n_chk++;
    if (err !== 1'b0) $display("FAIL err_cleared: err=%b, required 0", err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc = 0, pushes = 0;
    build_random(12);
    pulse_start(12);
    sym_rdy = 1'b0;
    while (pushes < 2 && cyc < 200) begin
      in_valid = (feed_q.size() != 0);
      in_data  = in_valid ? feed_q[0] : 8'h00;
      #1;
      if (in_valid && in_ready) void'(feed_q.pop_front());
      if (dec_bit_vld && dec_sym_vld) pushes++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_chk++;
    if (sym_vld !== 1'b1 || busy !== 1'b1)
      $display("FAIL mid_pre: sym_vld=%b busy=%b, required 1 1", sym_vld, busy);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({sym_vld, busy, in_ready, err, dec_clr, dec_bit_vld} !== 6'b000010)
      $display("FAIL mid_reset: sym_vld,busy,in_ready,err,dec_clr,dec_bit_vld=%b, required 000010",
               {sym_vld, busy, in_ready, err, dec_clr, dec_bit_vld});
    else n_pass++;
    rst = 1'b0;
    feed_q.delete();
    @(negedge clk);
  endtask

  task automatic test_restart_ignored();
    feed_q = '{8'h1B, 8'h00};
    exp_q  = '{1, 2, 3, 4};
    run_frame(4, 0, 3, "restart");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_len();
    test_backpressure();
    test_back_to_back();
    test_error();
    test_reset_mid();
    test_restart_ignored();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
